// File: rtl/board_write_arbiter.sv
// board_write_arbiter: 3x3 board storage with serialized clear / player / auto-move writes
module board_write_arbiter #(
  parameter int N_CELLS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  input  logic                   mv_req,
  input  logic [1:0]             mv_player,
  input  logic [1:0]             mv_row,
  input  logic [1:0]             mv_col,
  input  logic                   auto_req,
  input  logic [1:0]             auto_player,
  input  logic [3:0]             auto_seed,
  output logic                   mv_ack,
  output logic                   mv_rej,
  output logic                   auto_ack,
  output logic                   auto_full,
  output logic                   clr_done,
  output logic                   busy,
  output logic [1:0]             wr_row,
  output logic [1:0]             wr_col,
  output logic [2*N_CELLS-1:0]   board_flat
);
  typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;
  state_t     state;
  logic [3:0] idx, step, mv_idx, seed_mod;
  logic [1:0] mv_cell, scan_cell, scan_row, scan_col;
  logic       mv_ok;
  always_comb begin
    mv_idx    = 4'(mv_row) * 4'd3 + 4'(mv_col) - 4'd4;
    mv_cell   = board_flat[{mv_idx, 1'b0} +: 2];
    mv_ok     = (mv_row != 2'd0) && (mv_col != 2'd0) && (^mv_player) && (mv_cell == 2'd0);
    seed_mod  = auto_seed >= 4'd9 ? auto_seed - 4'd9 : auto_seed;
    scan_cell = board_flat[{idx, 1'b0} +: 2];
    scan_row  = idx < 4'd3 ? 2'd1 : idx < 4'd6 ? 2'd2 : 2'd3;
    scan_col  = idx < 4'd3 ? idx[1:0] + 2'd1 : idx < 4'd6 ? 2'(idx - 4'd2) : 2'(idx - 4'd5);
  end
  // busy stays high through the cycle carrying the completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      step       <= '0;
      board_flat <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
      mv_ack     <= 1'b0;
      mv_rej     <= 1'b0;
      auto_ack   <= 1'b0;
      auto_full  <= 1'b0;
      clr_done   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mv_ack    <= 1'b0;
      mv_rej    <= 1'b0;
      auto_ack  <= 1'b0;
      auto_full <= 1'b0;
      clr_done  <= 1'b0;
      busy      <= state != IDLE;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end else if (mv_req) begin
            if (mv_ok) begin
              board_flat[{mv_idx, 1'b0} +: 2] <= mv_player;
              wr_row <= mv_row;
              wr_col <= mv_col;
              mv_ack <= 1'b1;
            end else mv_rej <= 1'b1;
          end else if (auto_req) begin
            if (^auto_player) begin
              state <= SCAN;
              idx   <= seed_mod;
              step  <= '0;
              busy  <= 1'b1;
            end else auto_full <= 1'b1;
          end
        end
        CLEAR: begin
          board_flat[{idx, 1'b0} +: 2] <= 2'd0;
          if (idx == 4'd8) begin
            clr_done <= 1'b1;
            state    <= IDLE;
          end else idx <= idx + 4'd1;
        end
        SCAN: begin
          if (scan_cell == 2'd0) begin
            board_flat[{idx, 1'b0} +: 2] <= auto_player;
            wr_row   <= scan_row;
            wr_col   <= scan_col;
            auto_ack <= 1'b1;
            state    <= IDLE;
          end else if (step == 4'd8) begin
            auto_full <= 1'b1;
            state     <= IDLE;
          end else begin
            idx  <= idx == 4'd8 ? 4'd0 : idx + 4'd1;
            step <= step + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_write_arbiter.sv
// tb_board_write_arbiter: vector table with scoreboard queue plus multi-cycle sequences
module tb_board_write_arbiter;
  logic        clk = 1'b0, rst, clr_req, mv_req, auto_req;
  logic [1:0]  mv_player, mv_row, mv_col, auto_player, wr_row, wr_col;
  logic [3:0]  auto_seed;
  logic        mv_ack, mv_rej, auto_ack, auto_full, clr_done, busy;
  logic [17:0] board_flat;
  int          total = 0, passed = 0;

  typedef struct {
    logic [1:0]  p, r, c;
    logic        ack, rej;
    logic [17:0] board;
    logic [1:0]  wr, wc;
  } vec_t;
  vec_t vecs[9];
  vec_t q[$];

  board_write_arbiter dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .mv_req(mv_req), .mv_player(mv_player),
    .mv_row(mv_row), .mv_col(mv_col), .auto_req(auto_req), .auto_player(auto_player),
    .auto_seed(auto_seed), .mv_ack(mv_ack), .mv_rej(mv_rej), .auto_ack(auto_ack),
    .auto_full(auto_full), .clr_done(clr_done), .busy(busy), .wr_row(wr_row),
    .wr_col(wr_col), .board_flat(board_flat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] p, input logic [1:0] r, input logic [1:0] c);
    mv_req = 1'b1; mv_player = p; mv_row = r; mv_col = c;
    step();
    mv_req = 1'b0;
  endtask

  // n = edges from request sampling to the pulse, or -1 if the bound expires
  task automatic wait_pulse(input int sel, input int bound, output int n);
    logic hit;
    n = -1;
    for (int k = 1; k <= bound && n < 0; k++) begin
      step();
      hit = sel == 0 ? mv_ack : sel == 1 ? auto_ack : sel == 2 ? auto_full : clr_done;
      if (hit) n = k;
    end
  endtask

  initial begin
    int          n, cnt;
    vec_t        e;
    logic [17:0] expb;
    rst = 1'b1; clr_req = 0; mv_req = 0; auto_req = 0;
    mv_player = 0; mv_row = 0; mv_col = 0; auto_player = 0; auto_seed = 0;
    step(); step();
    chk("rst_board", board_flat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {mv_ack, mv_rej, auto_ack, auto_full, clr_done}, 0);
    chk("rst_wr", {wr_row, wr_col}, 0);
    rst = 1'b0;

    vecs[0] = '{2'd1, 2'd2, 2'd2, 1'b1, 1'b0, 18'h00100, 2'd2, 2'd2};
    vecs[1] = '{2'd2, 2'd2, 2'd2, 1'b0, 1'b1, 18'h00100, 2'd2, 2'd2};
    vecs[2] = '{2'd1, 2'd0, 2'd1, 1'b0, 1'b1, 18'h00100, 2'd2, 2'd2};
    vecs[3] = '{2'd3, 2'd1, 2'd1, 1'b0, 1'b1, 18'h00100, 2'd2, 2'd2};
    vecs[4] = '{2'd0, 2'd1, 2'd1, 1'b0, 1'b1, 18'h00100, 2'd2, 2'd2};
    vecs[5] = '{2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 18'h00120, 2'd1, 2'd3};
    vecs[6] = '{2'd1, 2'd3, 2'd3, 1'b1, 1'b0, 18'h10120, 2'd3, 2'd3};
    vecs[7] = '{2'd1, 2'd1, 2'd0, 1'b0, 1'b1, 18'h10120, 2'd3, 2'd3};
    vecs[8] = '{2'd2, 2'd3, 2'd1, 1'b1, 1'b0, 18'h12120, 2'd3, 2'd1};
    for (int i = 0; i < 9; i++) begin
      mv_req = 1'b1; mv_player = vecs[i].p; mv_row = vecs[i].r; mv_col = vecs[i].c;
      q.push_back(vecs[i]);
      step();
      e = q.pop_front();
      chk($sformatf("vec%0d_ack", i), mv_ack, e.ack);
      chk($sformatf("vec%0d_rej", i), mv_rej, e.rej);
      chk($sformatf("vec%0d_board", i), board_flat, e.board);
      chk($sformatf("vec%0d_wr", i), {wr_row, wr_col}, {e.wr, e.wc});
    end
    mv_req = 1'b0;

    // auto move wraps past occupied cells 7 and 8 to cell 0
    do_reset();
    do_move(2'd1, 2'd3, 2'd2);
    do_move(2'd1, 2'd3, 2'd3);
    auto_req = 1'b1; auto_player = 2'd2; auto_seed = 4'd7;
    wait_pulse(1, 20, n);
    auto_req = 1'b0;
    chk("wrap_latency", n, 4);
    chk("wrap_board", board_flat, 18'h14002);
    chk("wrap_wr", {wr_row, wr_col}, {2'd1, 2'd1});
    chk("wrap_busy", busy, 1);

    // fill the rest, then a full-board search
    expb = 18'h14002;
    for (int i = 1; i <= 6; i++) begin
      do_move(2'(i % 2 + 1), 2'(i / 3 + 1), 2'(i % 3 + 1));
      expb[2*i +: 2] = 2'(i % 2 + 1);
    end
    chk("fill_board", board_flat, expb);
    auto_req = 1'b1; auto_player = 2'd1; auto_seed = 4'd3;
    wait_pulse(2, 20, n);
    auto_req = 1'b0;
    chk("full_latency", n, 10);
    chk("full_board", board_flat, expb);

    // clear and move raised together on a full board
    clr_req = 1'b1; mv_req = 1'b1; mv_player = 2'd2; mv_row = 2'd1; mv_col = 2'd2;
    wait_pulse(3, 20, n);
    clr_req = 1'b0;
    chk("clr_latency", n, 10);
    chk("clr_board", board_flat, 0);
    chk("clr_busy", busy, 1);
    step();
    mv_req = 1'b0;
    chk("after_clr_ack", mv_ack, 1);
    chk("after_clr_board", board_flat, 18'h00008);
    chk("after_clr_busy", busy, 0);

    auto_req = 1'b1; auto_player = 2'd0;
    wait_pulse(2, 5, n);
    auto_req = 1'b0;
    chk("bad_auto_latency", n, 1);
    chk("bad_auto_board", board_flat, 18'h00008);

    // seed 13 reduces to start cell 4
    do_reset();
    auto_req = 1'b1; auto_player = 2'd1; auto_seed = 4'd13;
    wait_pulse(1, 20, n);
    auto_req = 1'b0;
    chk("seed13_latency", n, 2);
    chk("seed13_board", board_flat, 18'h00100);
    chk("seed13_wr", {wr_row, wr_col}, {2'd2, 2'd2});

    // reset in the 5th CLEAR cycle
    clr_req = 1'b1;
    repeat (5) step();
    chk("midclr_busy", busy, 1);
    chk("midclr_board", board_flat, 18'h00100);
    rst = 1'b1; clr_req = 1'b0;
    step();
    rst = 1'b0;
    chk("midclr_rst_board", board_flat, 0);
    chk("midclr_rst_busy", busy, 0);
    chk("midclr_rst_done", clr_done, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (clr_done) cnt++;
    end
    chk("midclr_no_done", cnt, 0);
    chk("midclr_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/board_write_arbiter.md
# board_write_arbiter

Owns the 3×3 game board storage and arbitrates every write to it. It takes requests from three sources: a board-clear sweep, a human player move, and an automatic timeout move that searches for an empty cell starting from a random index. It sits between the game FSM / player-movement logic and the win checker / video generator, which read the board from `board_flat`. Writes are serialized, so at most one cell changes per clock.

## Interface
Parameters:
- `N_CELLS`, default 9: number of board cells. Fixed 3×3; not to be overridden.

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: synchronous, active-high reset.
- `clr_req` input 1: request a full board clear (level).
- `mv_req` input 1: player move request (level).
- `mv_player` input 2: mark to write. 1 = P1, 2 = P2; 0 and 3 are invalid.
- `mv_row`, `mv_col` input 2 each: target cell, valid range 1..3.
- `auto_req` input 1: timeout auto-move request (level).
- `auto_player` input 2: mark for the auto move, same encoding as `mv_player`.
- `auto_seed` input 4: random start index for the search; reduced to 0..8.
- `mv_ack`, `mv_rej` output 1 each: one-cycle pulse; the move was written / refused.
- `auto_ack`, `auto_full` output 1 each: one-cycle pulse; the auto move was written / the board has no empty cell.
- `clr_done` output 1: one-cycle pulse at the end of a clear.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `wr_row`, `wr_col` output 2 each: coordinates of the last cell written by a move (1..3).
- `board_flat` output 18: cell index `i` occupies bits [2i+1:2i].
  - `i = (row-1)*3 + (col-1)`.
  - Cell value 0 = empty.

## Operation
- States: IDLE, CLEAR, SCAN.
- In IDLE, requests are sampled with priority `clr_req` > `mv_req` > `auto_req`. Lower-priority requests wait.
- **Clear:** go to CLEAR with `idx`=0.
  - Each cycle writes cell `idx` to 0 and increments `idx`.
  - After writing `idx`=8, pulse `clr_done` and return to IDLE.
- **Player move:** handled entirely in the IDLE cycle.
  - Refuse (`mv_rej`) if any of these holds: row or col is outside 1..3; player is 0 or 3; the target cell is non-zero.
  - Otherwise write the cell, update `wr_row`/`wr_col`, and pulse `mv_ack`.
- **Auto move:**
  - If `auto_player` is 0 or 3, pulse `auto_full`. (Invalid player is treated as no legal move.)
  - Otherwise load `idx` = `auto_seed` mod 9 (seed 9..15 maps to seed-9), clear the step counter, and go to SCAN.
- **SCAN:** one cell is examined per cycle.
  - If the cell is empty: write it, update `wr_row`/`wr_col`, pulse `auto_ack`, and go to IDLE.
  - Otherwise `idx` = (`idx`==8) ? 0 : `idx`+1, and increment the step counter.
  - After 9 occupied cells, pulse `auto_full` and go to IDLE. The board is unchanged.
- **Requester rule:** requesters deassert their request in the cycle their ack/rej/full/done pulse is seen.
  - A request still held afterwards is re-served as a new request on the next IDLE cycle.
- No preemption: requests that arrive during CLEAR or SCAN wait for IDLE.
- `rst` at any point, including mid-CLEAR or mid-SCAN:
  - Next state is IDLE.
  - `board_flat`=0, `idx`=0, `wr_row`=`wr_col`=0, all pulses 0, `busy`=0.

## Timing
- All outputs are registered. Reset values are all 0.
- Player move: accepted in IDLE cycle T. The cell is visible on `board_flat` and `mv_ack`/`mv_rej` is high in T+1. Latency is 1.
- Auto move: accepted at T, SCAN starts at T+1.
  - If k occupied cells are skipped (0..8), the write and `auto_ack` appear at T+2+k.
  - A fully occupied board gives `auto_full` at T+10.
- Clear: accepted at T; cells are zeroed at T+1..T+9 (visible one cycle after each write). `clr_done` is high at T+10, together with the board reading all zero.
- `busy` is high from T+1 until the cycle the completion pulse is issued, inclusive of that cycle.
- Simultaneous `clr_req` and `mv_req` in IDLE: the clear is served. The move is served in the first IDLE cycle after `clr_done`, and is then written to the cleared board.

## Test plan
- Reset, then move P1 at (2,2): `board_flat`=18'h00100 and `mv_ack` one cycle later. A second move by P2 at (2,2) gives `mv_rej` and the board is unchanged.
- `mv_row`=0, or `mv_player`=3: `mv_rej`, board unchanged.
- Cells 7 and 8 occupied; auto move with P2 and `auto_seed`=7: cells 7 and 8 are skipped, the search wraps and writes cell 0 (value 2). `auto_ack` arrives 4 cycles after acceptance; `wr_row`=1, `wr_col`=1.
- All 9 cells occupied; auto move: `auto_full` at +10, board unchanged. Also `auto_seed`=13 on an empty board: the search starts at cell 4.
- Board full; `clr_req` and `mv_req` raised in the same cycle: clear completes with `clr_done` at +10. The move is then accepted on the empty board.
- Assert `rst` during the 5th CLEAR cycle: the next cycle is IDLE, the board is all zero, no `clr_done` is issued, and `busy`=0.
